// File: rtl/modboard_io_pkg.sv
// Shared definitions for the modboard I/O glue: channel output modes and a
// constant-width helper used to size the debounce counter.
package modboard_io_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_INV    = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 32'sd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: two-flop synchroniser, consecutive-cycle debounce and a
// registered pulse on each accepted 0->1 transition.
module io_debounce #(
  parameter int DEB_CYCLES = 1024,
  parameter int DEB_W      = 10
) (
  input  logic pG0,
  input  logic pRST,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(1);

  logic             s1;
  logic             s2;
  logic [DEB_W-1:0] cnt;
  logic             accept;

  assign accept = (s2 != stable) && (cnt == CNT_LAST);

  // Synchroniser, debounce counter and rising-edge pulse.
  always_ff @(posedge pG0) begin
    if (!pRST) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= accept & s2;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/modboard_io_ctrl.sv
// CPLD I/O glue: debounced inputs drive registered outputs in pass, invert,
// toggle or blink mode; a free-running prescaler provides blink tick and heartbeat.
module modboard_io_ctrl
  import modboard_io_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DEB_CYCLES = 1024,
  parameter int DEB_W      = clog2(DEB_CYCLES),
  parameter int PRESC_BITS = 14
) (
  input  logic              pG0,
  input  logic              pRST,
  input  logic [N_CH-1:0]   in_raw,
  input  logic [2*N_CH-1:0] mode,
  output logic [N_CH-1:0]   out,
  output logic [N_CH-1:0]   rise,
  output logic              heartbeat
);

  localparam logic [PRESC_BITS-1:0] PRESC_ONE = PRESC_BITS'(1);

  logic [N_CH-1:0]       stable;
  logic [N_CH-1:0]       tgl;
  logic [N_CH-1:0]       blk;
  logic [N_CH-1:0]       out_next;
  logic [PRESC_BITS-1:0] ctr;
  logic                  tick;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    io_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .DEB_W     (DEB_W)
    ) u_deb (
      .pG0   (pG0),
      .pRST  (pRST),
      .raw   (in_raw[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

  assign tick      = &ctr;
  assign heartbeat = ctr[PRESC_BITS-1];

  // Free-running prescaler; wraps silently.
  always_ff @(posedge pG0) begin
    if (!pRST) begin
      ctr <= '0;
    end else begin
      ctr <= ctr + PRESC_ONE;
    end
  end

  // Toggle flips on every rise regardless of mode; blink runs only while the input is held.
  always_ff @(posedge pG0) begin
    if (!pRST) begin
      tgl <= '0;
      blk <= '0;
    end else begin
      tgl <= tgl ^ rise;
      for (int i = 0; i < N_CH; i++) begin
        if (!stable[i]) begin
          blk[i] <= 1'b0;
        end else if (tick) begin
          blk[i] <= ~blk[i];
        end else begin
          blk[i] <= blk[i];
        end
      end
    end
  end

  // Per-channel output selection.
  always_comb begin
    out_next = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode[2*i +: 2])
        MODE_PASS:   out_next[i] = stable[i];
        MODE_INV:    out_next[i] = ~stable[i];
        MODE_TOGGLE: out_next[i] = tgl[i];
        MODE_BLINK:  out_next[i] = blk[i];
        default:     out_next[i] = 1'b0;
      endcase
    end
  end

  // Output register.
  always_ff @(posedge pG0) begin
    if (!pRST) begin
      out <= '0;
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: tb/tb_modboard_io_ctrl.sv
// Self-checking bench for modboard_io_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_modboard_io_ctrl;

  localparam int N_CH = 2;
  localparam int DEB  = 4;
  localparam int PB   = 4;
  localparam int PER  = 1 << PB;

  logic            pG0;
  logic            pRST;
  logic [N_CH-1:0] in_raw;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0] out;
  logic [N_CH-1:0] rise;
  logic            heartbeat;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // behavioural model state
  int m_s1[N_CH];
  int m_s2[N_CH];
  int m_st[N_CH];
  int m_run[N_CH];
  int m_rise[N_CH];
  int m_t[N_CH];
  int m_b[N_CH];
  int m_out[N_CH];
  int m_n = 0;

  modboard_io_ctrl #(
    .N_CH(N_CH), .DEB_CYCLES(DEB), .DEB_W(2), .PRESC_BITS(PB)
  ) dut (
    .pG0(pG0), .pRST(pRST), .in_raw(in_raw), .mode(mode),
    .out(out), .rise(rise), .heartbeat(heartbeat)
  );

  initial pG0 = 1'b0;
  always #5 pG0 = ~pG0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: sync is a 2-deep delay, debounce accepts after DEB consecutive differing samples,
  // blink parity counts ticks while held, toggle parity counts rises; out follows mode one edge later.
  task automatic model_step();
    int md;
    bit tick;
    if (pRST !== 1'b1) begin
      for (int c = 0; c < N_CH; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_st[c] = 0; m_run[c] = 0;
        m_rise[c] = 0; m_t[c] = 0; m_b[c] = 0; m_out[c] = 0;
      end
      m_n = 0;
    end else begin
      tick = ((m_n % PER) == PER - 1);
      for (int c = 0; c < N_CH; c++) begin
        md = int'(mode[2*c +: 2]);
        m_out[c] = (md == 0) ? m_st[c] : (md == 1) ? 1 - m_st[c] : (md == 2) ? m_t[c] : m_b[c];
        m_t[c] = m_t[c] ^ m_rise[c];
        if (m_st[c] == 0) m_b[c] = 0;
        else if (tick) m_b[c] = 1 - m_b[c];
        m_rise[c] = 0;
        if (m_s2[c] != m_st[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_st[c] = m_s2[c];
            m_run[c] = 0;
            m_rise[c] = m_st[c];
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = int'(in_raw[c]);
      end
      m_n++;
    end
  endtask

  initial forever begin
    @(posedge pG0);
    model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge pG0);
    if (chk_en) begin
      check("model_out", 32'(out), 32'({m_out[1] != 0, m_out[0] != 0}));
      check("model_rise", 32'(rise), 32'({m_rise[1] != 0, m_rise[0] != 0}));
      check("model_heartbeat", 32'(heartbeat), 32'((m_n % PER) >= PER / 2));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge pG0);
  endtask

  task automatic do_reset(input int n);
    pRST = 1'b0;
    in_raw = '0;
    cycles(n);
    pRST = 1'b1;
  endtask

  initial begin
    int first_out, rise_k, rise_cnt, bad, hb_last, hb_per, o_last, o_per;
    logic hb_prev, o_prev;
    logic [2:0] tog_exp;
    pRST = 1'b0;
    in_raw = 2'b11;
    mode = 4'b0101;
    @(negedge pG0);
    chk_en = 1'b1;

    // 1: reset with INV mode and inputs high
    for (int i = 0; i < 3; i++) begin
      check("rst_out", 32'(out), 32'd0);
      check("rst_rise", 32'(rise), 32'd0);
      check("rst_hb", 32'(heartbeat), 32'd0);
      @(negedge pG0);
    end
    pRST = 1'b1;
    @(negedge pG0);
    check("inv_after_release", 32'(out), 32'd3);
    check("rise_after_release", 32'(rise), 32'd0);
    in_raw = 2'b00;
    cycles(10);

    // 2: debounce latency in PASS
    mode = 4'b0000;
    cycles(2);
    in_raw[0] = 1'b1;
    first_out = 0; rise_k = 0; rise_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge pG0);
      if (rise[0]) begin rise_k = k; rise_cnt++; end
      if (out[0] && first_out == 0) first_out = k;
    end
    check("pass_latency", 32'(first_out), 32'd7);
    check("rise_cycle", 32'(rise_k), 32'd6);
    check("rise_count", 32'(rise_cnt), 32'd1);

    // 3: 3-cycle glitch on channel 1 is rejected
    in_raw[1] = 1'b1;
    cycles(3);
    in_raw[1] = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge pG0);
      if (out[1] || rise[1]) bad++;
    end
    check("glitch_reject", 32'(bad), 32'd0);

    // 4: toggle mode, three presses, mode round trip
    do_reset(2);
    mode = 4'b0010;
    cycles(10);
    tog_exp = 3'b101;
    for (int p = 0; p < 3; p++) begin
      in_raw[0] = 1'b1;
      cycles(10);
      check("toggle_pressed", 32'(out[0]), 32'(tog_exp[p]));
      in_raw[0] = 1'b0;
      cycles(10);
      check("toggle_released", 32'(out[0]), 32'(tog_exp[p]));
    end
    mode = 4'b0000;
    cycles(2);
    check("toggle_to_pass", 32'(out[0]), 32'd0);
    mode = 4'b0010;
    @(negedge pG0);
    check("toggle_restored", 32'(out[0]), 32'd1);

    // 5: blink and heartbeat periods
    do_reset(2);
    mode = 4'b1111;
    in_raw[0] = 1'b1;
    hb_prev = heartbeat; o_prev = out[0];
    hb_last = -1; hb_per = 0; o_last = -1; o_per = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge pG0);
      if (heartbeat && !hb_prev) begin
        if (hb_last >= 0) hb_per = k - hb_last;
        hb_last = k;
      end
      if (out[0] != o_prev) begin
        if (o_last >= 0) o_per = k - o_last;
        o_last = k;
      end
      hb_prev = heartbeat; o_prev = out[0];
    end
    check("heartbeat_period", 32'(hb_per), 32'(PER));
    check("blink_period", 32'(o_per), 32'(PER));
    in_raw[0] = 1'b0;
    cycles(10);
    check("blink_off", 32'(out[0]), 32'd0);

    // 6: reset mid-debounce and mid-blink
    mode = 4'b0000;
    in_raw[1] = 1'b1;
    cycles(4);
    do_reset(2);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge pG0);
      if (rise != 2'b00) bad++;
    end
    check("no_rise_after_reset", 32'(bad), 32'd0);
    mode = 4'b1111;
    in_raw = 2'b11;
    cycles(30);
    pRST = 1'b0;
    in_raw = 2'b00;
    @(negedge pG0);
    check("midblink_out", 32'(out), 32'd0);
    check("midblink_hb", 32'(heartbeat), 32'd0);
    pRST = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge pG0);
      if (rise != 2'b00 || out != 2'b00) bad++;
    end
    check("midblink_quiet", 32'(bad), 32'd0);

    // random phase
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(39) == 0) begin
        pRST = 1'b0;
        cycles($urandom_range(2, 1));
        pRST = 1'b1;
      end
      in_raw = N_CH'($urandom_range(3));
      if ($urandom_range(7) == 0) mode = 4'($urandom_range(15));
      cycles($urandom_range(12, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
